lcd_read: RTL and testbench
===========================

# lcd_read

Register-read engine for the LCD controller's SPI port. It is the read-direction counterpart of the LCD write path: it sends one command byte with dc low, then clocks in 1–4 parameter bytes from the panel (for example ID or status). The block sits beside the write path under `control`, which muxes the shared cs/dc/sclk/mosi pins to this block while `busy` is high.

## Interface
Parameters:
- `CLK_DIV`, default 2: number of sys_clk cycles per sclk half-period. Must be ≥1.
- `MAX_BYTES`, default 4: maximum read length. Also sets the width of `rd_data` (8×MAX_BYTES).

Ports:
- `sys_clk`  in  1  system clock.
- `sys_rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  single-cycle request. Sampled only while `busy`=0.
- `cmd`  in  8  command byte, captured when `start` is accepted.
- `rd_len`  in  3  number of bytes to read, captured when `start` is accepted.
- `busy`  out  1  high from the cycle after accept through the DONE cycle.
- `rd_valid`  out  1  one-cycle pulse when `rd_data` is updated.
- `rd_data`  out  32  received bytes, right-justified; the last byte is in [7:0].
- `cs`  out  1  SPI chip select, active-low.
- `dc`  out  1  0 = command phase, 1 = data phase.
- `sclk`  out  1  SPI clock, mode 0 (idles low).
- `mosi`  out  1  serial data out, MSB first.
- `miso`  in  1  serial data in from the panel.

## Operation
- FSM states: IDLE → CS_SETUP → CMD → [DUMMY] → READ → CS_HOLD → DONE → IDLE.
- IDLE:
  - Outputs: cs=1, dc=1, sclk=0, mosi=0.
  - When `start`=1, capture `cmd` and `rd_len`, clear `rd_data` to 0, and go to CS_SETUP.
- `rd_len` handling: 0 is treated as 1; values above MAX_BYTES are clamped to MAX_BYTES.
- CS_SETUP: cs=0, dc=0, sclk=0, for CLK_DIV cycles.
- Bit cell, used in CMD, DUMMY and READ:
  - sclk low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - mosi updates on the first low cycle.
  - miso is sampled on the sys_clk edge where sclk rises.
- CMD: 8 bit cells with dc=0, shifting `cmd` out MSB first.
- READ: 8×len bit cells with dc=1 and mosi=0. Each sampled bit shifts into `rd_data` from the LSB side.
- CS_HOLD: sclk=0 and cs=0, for CLK_DIV cycles.
- DONE: one cycle with cs=1, `rd_valid`=1, `busy`=1. The next cycle is IDLE.
- `rd_data` holds its value until the next accepted `start`.
- A `start` while `busy`=1 is ignored and is not queued.
- Reset mid-transaction: all outputs return immediately to their reset values and the FSM goes to IDLE. No `rd_valid` is produced.

## Timing
- Reset values: cs=1, dc=1, sclk=0, mosi=0, busy=0, rd_valid=0, rd_data=0.
- Latency with `start` accepted at edge N:
  - cs falls at N+1.
  - `rd_valid` is high in cycle N+1+CLK_DIV·(18+16·len).
  - With the DUMMY phase compiled in, add 2·CLK_DIV.
- Example: CLK_DIV=2, len=4 gives `rd_valid` at N+165.
- `busy` is high from N+1 through the DONE cycle inclusive. A new `start` is accepted no earlier than one cycle after `rd_valid`.
- sclk never has a partial pulse. cs edges occur only while sclk=0.

## Configuration
- `LCD_READ_DUMMY_CLK_EN` defined:
  - One DUMMY bit cell is inserted between CMD and READ, with dc=1 and mosi=0.
  - miso is ignored during DUMMY.
  - This matches panels that require a dummy clock before read data (multi-byte ID reads).
- Undefined: the DUMMY state does not exist and READ directly follows CMD.

## Structure
- Shared package `lcd_pkg` holds:
  - the FSM state enum;
  - command constants `LCD_CMD_RDDID` = 8'h04 and `LCD_CMD_RDDST` = 8'h09;
  - the `rd_len` width constant.
- One sub-module, `lcd_spi_clkgen`:
  - a half-period counter plus an sclk toggle;
  - produces `fall_tick` and `rise_tick` strobes;
  - enabled only in the bit-cell states.
- The FSM, bit counter and shift registers live in `lcd_read`.

## Test plan
- Reset: assert `sys_rst_n`=0 with no clock running → cs=1, dc=1, sclk=0, mosi=0, busy=0, rd_valid=0, rd_data=0.
- Macro undefined, CLK_DIV=2, cmd=8'h04, rd_len=3, panel model drives 85,85,52 (hex):
  - mosi carries 00000100 while dc=0;
  - exactly 32 sclk pulses;
  - rd_data=32'h00858552;
  - rd_valid at N+133.
- Macro defined, same stimulus → 33 sclk pulses, rd_data=32'h00858552, rd_valid at N+137.
- rd_len=0, panel drives A5 → rd_data=32'h000000A5. rd_len=7 → exactly 4 bytes read. A `start` pulse mid-transaction causes no change.
- Assert reset during READ byte 2 → cs=1 and sclk=0 asynchronously, no rd_valid. A following cmd=8'h09 read of 4 bytes completes normally.
- Back-to-back: `start` issued one cycle after rd_valid is accepted → cs falls one cycle later.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD SPI read path.
// Build option: LCD_READ_DUMMY_CLK_EN adds a DUMMY bit cell.
package lcd_pkg;

  localparam int RD_LEN_W = 3;

  localparam logic [7:0] LCD_CMD_RDDID = 8'h04;
  localparam logic [7:0] LCD_CMD_RDDST = 8'h09;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CS_SETUP = 3'd1,
    ST_CMD      = 3'd2,
`ifdef LCD_READ_DUMMY_CLK_EN
    ST_DUMMY    = 3'd3,
`endif
    ST_READ     = 3'd4,
    ST_CS_HOLD  = 3'd5,
    ST_DONE     = 3'd6
  } rd_state_e;

  // A zero length still reads one byte; long requests saturate.
  function automatic logic [RD_LEN_W-1:0] clamp_len(
    input logic [RD_LEN_W-1:0] len,
    input int unsigned         max_bytes
  );
    logic [RD_LEN_W-1:0] r;
    r = len;
    if (len == '0)
      r = RD_LEN_W'(1);
    else if (32'(len) > max_bytes)
      r = RD_LEN_W'(max_bytes);
    return r;
  endfunction

endpackage

// File: rtl/lcd_spi_clkgen.sv
// Mode-0 SPI clock generator: half-period counter with sclk toggle.
// Ticks mark the sys_clk edge where sclk rises or falls.
module lcd_spi_clkgen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sclk,
  output logic fall_tick,
  output logic rise_tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          half_done;

  assign half_done = en && (cnt == CW'(CLK_DIV - 1));
  assign rise_tick = half_done && !sclk;
  assign fall_tick = half_done && sclk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (half_done) begin
      cnt  <= '0;
      sclk <= ~sclk;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/lcd_read.sv
// LCD register-read engine: command byte out, 1..MAX_BYTES bytes in.
// Build option: LCD_READ_DUMMY_CLK_EN inserts one dummy clock before data.
module lcd_read
  import lcd_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter int MAX_BYTES = 4
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   start,
  input  logic [7:0]             cmd,
  input  logic [RD_LEN_W-1:0]    rd_len,
  output logic                   busy,
  output logic                   rd_valid,
  output logic [8*MAX_BYTES-1:0] rd_data,
  output logic                   cs,
  output logic                   dc,
  output logic                   sclk,
  output logic                   mosi,
  input  logic                   miso
);

  localparam int DW = 8 * MAX_BYTES;
  localparam int BW = $clog2(DW + 1);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  rd_state_e           state;
  rd_state_e           state_nxt;
  logic [7:0]          tx_q;
  logic [RD_LEN_W-1:0] len_q;
  logic [BW-1:0]       bit_cnt;
  logic [BW-1:0]       last_bit;
  logic [CW-1:0]       wait_cnt;
  logic                wait_done;
  logic                cell_en;
  logic                cell_last;
  logic                fall_tick;
  logic                rise_tick;
  logic                accept;

  assign accept    = (state == ST_IDLE) && start;
  assign last_bit  = BW'({len_q, 3'b000}) - BW'(1);
  assign wait_done = (wait_cnt == CW'(CLK_DIV - 1));

  lcd_spi_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .clk       (sys_clk),
    .rst_n     (sys_rst_n),
    .en        (cell_en),
    .sclk      (sclk),
    .fall_tick (fall_tick),
    .rise_tick (rise_tick)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    cell_last = 1'b1;
    unique case (state)
      ST_CMD:  cell_last = (bit_cnt == BW'(7));
      ST_READ: cell_last = (bit_cnt == last_bit);
      default: cell_last = 1'b1;
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:
        if (start) state_nxt = ST_CS_SETUP;
      ST_CS_SETUP:
        if (wait_done) state_nxt = ST_CMD;
      ST_CMD:
        if (fall_tick && cell_last)
`ifdef LCD_READ_DUMMY_CLK_EN
          state_nxt = ST_DUMMY;
`else
          state_nxt = ST_READ;
`endif
`ifdef LCD_READ_DUMMY_CLK_EN
      ST_DUMMY:
        if (fall_tick) state_nxt = ST_READ;
`endif
      ST_READ:
        if (fall_tick && cell_last) state_nxt = ST_CS_HOLD;
      ST_CS_HOLD:
        if (wait_done) state_nxt = ST_DONE;
      ST_DONE:
        state_nxt = ST_IDLE;
      default:
        state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cs       = 1'b0;
    dc       = 1'b1;
    mosi     = 1'b0;
    busy     = 1'b1;
    rd_valid = 1'b0;
    cell_en  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        cs   = 1'b1;
        busy = 1'b0;
      end
      ST_CS_SETUP: dc = 1'b0;
      ST_CMD: begin
        dc      = 1'b0;
        mosi    = tx_q[7];
        cell_en = 1'b1;
      end
`ifdef LCD_READ_DUMMY_CLK_EN
      ST_DUMMY: cell_en = 1'b1;
`endif
      ST_READ:    cell_en = 1'b1;
      ST_CS_HOLD: cell_en = 1'b0;
      ST_DONE: begin
        cs       = 1'b1;
        rd_valid = 1'b1;
      end
      default: begin
        cs   = 1'b1;
        busy = 1'b0;
      end
    endcase
  end

  // mosi advances at the end of each cell so the next bit is set up while sclk is low.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tx_q     <= '0;
      len_q    <= RD_LEN_W'(1);
      bit_cnt  <= '0;
      wait_cnt <= '0;
      rd_data  <= '0;
    end else begin
      if (accept) begin
        tx_q    <= cmd;
        len_q   <= clamp_len(rd_len, MAX_BYTES);
        rd_data <= '0;
      end else begin
        if (state == ST_CMD && fall_tick)
          tx_q <= {tx_q[6:0], 1'b0};
        if (state == ST_READ && rise_tick)
          rd_data <= {rd_data[DW-2:0], miso};
      end

      if ((state == ST_CS_SETUP || state == ST_CS_HOLD) && !wait_done)
        wait_cnt <= wait_cnt + CW'(1);
      else
        wait_cnt <= '0;

      if (accept)
        bit_cnt <= '0;
      else if (fall_tick)
        bit_cnt <= cell_last ? '0 : bit_cnt + BW'(1);
    end
  end

endmodule

// File: tb/tb_lcd_read.sv
// Self-checking bench for lcd_read with a mode-0 SPI panel model.
// Expectations follow LCD_READ_DUMMY_CLK_EN when it is defined.
module tb_lcd_read;
  import lcd_pkg::*;

  localparam int CD = 2;
  localparam int MB = 4;
`ifdef LCD_READ_DUMMY_CLK_EN
  localparam int DUM = 1;
`else
  localparam int DUM = 0;
`endif

  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        clk_en    = 1'b0;
  logic        start     = 1'b0;
  logic [7:0]  cmd       = 8'h00;
  logic [2:0]  rd_len    = 3'd0;
  logic        miso      = 1'b0;
  logic        busy, rd_valid, cs, dc, sclk, mosi;
  logic [31:0] rd_data;

  int checks = 0;
  int errors = 0;

  lcd_read #(
    .CLK_DIV   (CD),
    .MAX_BYTES (MB)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start     (start),
    .cmd       (cmd),
    .rd_len    (rd_len),
    .busy      (busy),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .cs        (cs),
    .dc        (dc),
    .sclk      (sclk),
    .mosi      (mosi),
    .miso      (miso)
  );

  always #5 if (clk_en) sys_clk = ~sys_clk;

  // Panel model and bus monitor.
  logic [7:0] panel [4];
  logic       prev_sclk = 1'b0;
  logic       prev_dc   = 1'b1;
  logic       prev_cs   = 1'b1;
  logic       prev_rst  = 1'b0;
  int         fcnt = 0;
  int         pulses = 0;
  int         last_pulses = 0;
  int         viol = 0;
  int         idx;
  logic [7:0] cmd_cap  = 8'h00;
  logic [7:0] last_cmd = 8'h00;

  always @(negedge sys_clk) begin
    if (cs) begin
      if (!prev_cs) begin
        last_pulses = pulses;
        last_cmd    = cmd_cap;
      end
      fcnt    = 0;
      pulses  = 0;
      cmd_cap = 8'h00;
    end else begin
      if (!prev_sclk && sclk) begin
        pulses++;
        if (!dc) cmd_cap = {cmd_cap[6:0], mosi};
      end
      if (prev_sclk && !sclk && prev_dc) fcnt++;
    end
    if (sys_rst_n && prev_rst && (cs != prev_cs) && (sclk || prev_sclk))
      viol++;
    prev_sclk = sclk;
    prev_dc   = dc;
    prev_cs   = cs;
    prev_rst  = sys_rst_n;
    idx  = fcnt - DUM;
    miso = (idx >= 0 && idx < 32) ? panel[idx / 8][7 - (idx % 8)] : 1'b0;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Starts at a negedge in IDLE, ends at the negedge of the cycle after DONE.
  task automatic run_txn(input logic [7:0] c, input logic [2:0] l,
                         input logic [31:0] pb, input logic [31:0] exp_d,
                         input int eff, input bit inject, input string tag);
    int k;
    bit seen;
    for (int i = 0; i < 4; i++) panel[i] = pb[31 - 8 * i -: 8];
    start  = 1'b1;
    cmd    = c;
    rd_len = l;
    @(posedge sys_clk);
    #1 start = 1'b0;
    @(negedge sys_clk);
    chk({tag, ".cs_fall"}, 32'(cs), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    k    = 0;
    seen = 1'b0;
    while (!seen && k < 2000) begin
      @(posedge sys_clk);
      k++;
      @(negedge sys_clk);
      if (inject && (k == 40 || k == 41)) begin
        start  = (k == 40);
        cmd    = 8'hFF;
        rd_len = 3'd1;
      end
      if (rd_valid) seen = 1'b1;
    end
    chk({tag, ".rd_valid_seen"}, 32'(seen), 32'd1);
    chk({tag, ".latency"}, 32'(k + 1), 32'(1 + CD * (18 + 16 * eff + 2 * DUM)));
    chk({tag, ".rd_data"}, rd_data, exp_d);
    @(posedge sys_clk);
    @(negedge sys_clk);
    chk({tag, ".valid_pulse"}, 32'(rd_valid), 32'd0);
    chk({tag, ".busy_off"}, 32'(busy), 32'd0);
    chk({tag, ".pulses"}, 32'(last_pulses), 32'(8 + 8 * eff + DUM));
    chk({tag, ".mosi_cmd"}, 32'(last_cmd), 32'(c));
    chk({tag, ".cs_edges"}, 32'(viol), 32'd0);
    chk({tag, ".hold"}, rd_data, exp_d);
  endtask

  typedef struct {
    logic [7:0]  c;
    logic [2:0]  l;
    logic [31:0] pb;
    logic [31:0] exp_d;
    int          eff;
    bit          inject;
    bit          gap;
  } vec_t;

  vec_t vecs [6];
  bit   vseen;

  initial begin
    vecs[0] = '{8'h04, 3'd3, 32'h85855200, 32'h00858552, 3, 1'b0, 1'b1};
    vecs[1] = '{8'h04, 3'd0, 32'hA5000000, 32'h000000A5, 1, 1'b0, 1'b1};
    vecs[2] = '{8'h0A, 3'd7, 32'h12345678, 32'h12345678, 4, 1'b0, 1'b1};
    vecs[3] = '{8'h5A, 3'd2, 32'hF00F0000, 32'h0000F00F, 2, 1'b1, 1'b1};
    vecs[4] = '{8'h04, 3'd1, 32'h3C000000, 32'h0000003C, 1, 1'b0, 1'b0};
    vecs[5] = '{8'hC3, 3'd4, 32'h0180FF7E, 32'h0180FF7E, 4, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) panel[i] = 8'h00;

    #20;
    chk("rst.cs", 32'(cs), 32'd1);
    chk("rst.dc", 32'(dc), 32'd1);
    chk("rst.sclk", 32'(sclk), 32'd0);
    chk("rst.mosi", 32'(mosi), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.rd_valid", 32'(rd_valid), 32'd0);
    chk("rst.rd_data", rd_data, 32'd0);
    sys_rst_n = 1'b1;
    #3 clk_en = 1'b1;
    repeat (3) @(negedge sys_clk);

    for (int v = 0; v < 6; v++) begin
      if (vecs[v].gap) repeat (3) @(negedge sys_clk);
      run_txn(vecs[v].c, vecs[v].l, vecs[v].pb, vecs[v].exp_d,
              vecs[v].eff, vecs[v].inject, $sformatf("v%0d", v));
      if (vecs[v].inject) begin
        repeat (3) @(negedge sys_clk);
        chk($sformatf("v%0d.no_queue", v), 32'(busy), 32'd0);
      end
    end

    // Asynchronous reset in the middle of the second read byte.
    repeat (3) @(negedge sys_clk);
    panel[0] = 8'h85; panel[1] = 8'h85; panel[2] = 8'h52; panel[3] = 8'h00;
    start  = 1'b1;
    cmd    = LCD_CMD_RDDID;
    rd_len = 3'd3;
    @(posedge sys_clk);
    #1 start = 1'b0;
    repeat (80) @(posedge sys_clk);
    for (int i = 0; i < 8 && !sclk; i++) @(posedge sys_clk);
    #1;
    chk("rrst.pre_dc", 32'(dc), 32'd1);
    chk("rrst.pre_sclk", 32'(sclk), 32'd1);
    #1 sys_rst_n = 1'b0;
    #1;
    chk("rrst.cs", 32'(cs), 32'd1);
    chk("rrst.sclk", 32'(sclk), 32'd0);
    chk("rrst.busy", 32'(busy), 32'd0);
    chk("rrst.rd_data", rd_data, 32'd0);
    vseen = 1'b0;
    repeat (5) begin
      @(negedge sys_clk);
      if (rd_valid) vseen = 1'b1;
    end
    sys_rst_n = 1'b1;
    repeat (4) begin
      @(negedge sys_clk);
      if (rd_valid) vseen = 1'b1;
    end
    chk("rrst.no_valid", 32'(vseen), 32'd0);
    viol = 0;
    run_txn(LCD_CMD_RDDST, 3'd4, 32'hDEADBEEF, 32'hDEADBEEF, 4, 1'b0, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
